// File: rtl/delay_line_reader.sv
// Fractional-delay tap reader for a RAM-backed circular delay line.
// It fetches the two samples around the requested delay and outputs their linear interpolation.
module delay_line_reader #(
    parameter int WIDTH  = 12,
    parameter int ADDR_W = 11,
    parameter int FRAC_W = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          wr_ptr,
    input  logic [ADDR_W+FRAC_W-1:0]   delay,
    output logic                       rd_en,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic signed [WIDTH-1:0]    rd_data,
    output logic signed [WIDTH-1:0]    out,
    output logic                       valid,
    output logic                       busy
);

    localparam int PW = WIDTH + FRAC_W + 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        CAP  = 3'd3,
        MUL  = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t                    state_reg, state_next;
    logic [FRAC_W-1:0]         frac_reg;
    logic signed [WIDTH-1:0]   s0_reg;
    logic signed [PW-1:0]      p_reg;
    logic signed [WIDTH-1:0]   out_reg;
    logic                      rd_en_reg;
    logic [ADDR_W-1:0]         rd_addr_reg;

    logic [ADDR_W-1:0]         d_int;
    logic [ADDR_W-1:0]         d_clamp;
    logic [ADDR_W-1:0]         a0;
    logic signed [WIDTH:0]     diff;
    logic signed [FRAC_W:0]    frac_s;
    logic signed [PW-1:0]      prod;
    logic signed [PW-1:0]      shifted;
    logic signed [PW-1:0]      sum_full;

    // Keep both taps away from the slot the writer is filling right now.
    assign d_int   = delay[ADDR_W+FRAC_W-1:FRAC_W];
    assign d_clamp = (d_int == '0) ? ADDR_W'(1)
                   : (d_int == '1) ? {{(ADDR_W-1){1'b1}}, 1'b0}
                   : d_int;
    assign a0      = wr_ptr - d_clamp;

    // During CAP, rd_data holds the older tap s1.
    assign diff     = {rd_data[WIDTH-1], rd_data} - {s0_reg[WIDTH-1], s0_reg};
    assign frac_s   = {1'b0, frac_reg};
    assign prod     = diff * frac_s;
    assign shifted  = p_reg >>> FRAC_W;
    assign sum_full = shifted + PW'(s0_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RD0;
            RD0:     state_next = RD1;
            RD1:     state_next = CAP;
            CAP:     state_next = MUL;
            MUL:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= IDLE;
            frac_reg    <= '0;
            s0_reg      <= '0;
            p_reg       <= '0;
            out_reg     <= '0;
            rd_en_reg   <= 1'b0;
            rd_addr_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        rd_en_reg   <= 1'b1;
                        rd_addr_reg <= a0;
                        frac_reg    <= delay[FRAC_W-1:0];
                    end
                end
                RD0: rd_addr_reg <= rd_addr_reg - ADDR_W'(1);
                RD1: begin
                    rd_en_reg <= 1'b0;
                    s0_reg    <= rd_data;
                end
                CAP:  p_reg   <= prod;
                // The interpolated value lies between s0 and s1, so truncation is lossless.
                MUL:  out_reg <= WIDTH'(sum_full);
                default: ;
            endcase
        end
    end

    assign rd_en   = rd_en_reg;
    assign rd_addr = rd_addr_reg;
    assign out     = out_reg;
    assign valid   = (state_reg == DONE);
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_delay_line_reader.sv
// Directed bench for delay_line_reader: a table of tap/interpolation vectors
// plus hand-written handshake, delay-change and reset-abort sequences.
module tb_delay_line_reader;

    logic               clk;
    logic               rstn;
    logic               start;
    logic [10:0]        wr_ptr;
    logic [18:0]        delay;
    logic               rd_en;
    logic [10:0]        rd_addr;
    logic signed [11:0] rd_data;
    logic signed [11:0] out;
    logic               valid;
    logic               busy;

    logic signed [11:0] mem [2048];

    int checks;
    int failures;

    typedef struct {
        logic [10:0] wr;
        logic [18:0] dl;
        int          s0;
        int          s1;
        int          a0;
        int          a1;
        int          exp_out;
    } vec_t;

    vec_t vecs [7];

    delay_line_reader #(.WIDTH(12), .ADDR_W(11), .FRAC_W(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .wr_ptr  (wr_ptr),
        .delay   (delay),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .out     (out),
        .valid   (valid),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model: data appears one cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input bit perturb, input string tag);
        logic [5:0] en_seq;
        logic [5:0] val_seq;
        logic [5:0] busy_seq;
        int ad0, ad1, got;
        en_seq = '0; val_seq = '0; busy_seq = '0;
        ad0 = 0; ad1 = 0; got = 0;
        mem[v.a0[10:0]] = 12'(v.s0);
        mem[v.a1[10:0]] = 12'(v.s1);
        @(negedge clk);
        wr_ptr = v.wr;
        delay  = v.dl;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            en_seq[c-1]   = rd_en;
            val_seq[c-1]  = valid;
            busy_seq[c-1] = busy;
            if (c == 1) ad0 = int'(rd_addr);
            if (c == 2) ad1 = int'(rd_addr);
            if (c == 5) got = int'(out);
            if (c == 1 && perturb) begin
                delay  = '0;
                wr_ptr = 11'd500;
            end
            if (c < 6) begin
                @(posedge clk);
                #1;
            end
        end
        $display("op %s wr=%0d delay=0x%05h addr=%0d,%0d out=%0d exp=%0d",
                 tag, v.wr, v.dl, ad0, ad1, got, v.exp_out);
        check({tag, " rd_en seq"}, int'(en_seq), 6'b000011);
        check({tag, " valid seq"}, int'(val_seq), 6'b010000);
        check({tag, " busy seq"}, int'(busy_seq), 6'b011111);
        check({tag, " addr0"}, ad0, v.a0);
        check({tag, " addr1"}, ad1, v.a1);
        check({tag, " out"}, got, v.exp_out);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first_at;
        int second_at;
        int pulse_out;
        int saw_valid;

        checks   = 0;
        failures = 0;
        rd_data  = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 12'(i);

        vecs[0] = '{wr: 11'd100, dl: 19'h00A00, s0: 90,    s1: 89,   a0: 90,   a1: 89,   exp_out: 90};
        vecs[1] = '{wr: 11'd100, dl: 19'h00A40, s0: 100,   s1: 200,  a0: 90,   a1: 89,   exp_out: 125};
        vecs[2] = '{wr: 11'd100, dl: 19'h00A80, s0: 100,   s1: -100, a0: 90,   a1: 89,   exp_out: 0};
        vecs[3] = '{wr: 11'd100, dl: 19'h00AFF, s0: -2048, s1: 2047, a0: 90,   a1: 89,   exp_out: 2031};
        vecs[4] = '{wr: 11'd3,   dl: 19'h00510, s0: 7,     s1: -5,   a0: 2046, a1: 2045, exp_out: 6};
        vecs[5] = '{wr: 11'd3,   dl: 19'h00001, s0: 300,   s1: -300, a0: 2,    a1: 1,    exp_out: 297};
        vecs[6] = '{wr: 11'd3,   dl: 19'h7FFC0, s0: 0,     s1: 1000, a0: 5,    a1: 4,    exp_out: 750};

        // Reset held with start asserted: everything stays at zero.
        rstn   = 1'b0;
        start  = 1'b1;
        wr_ptr = 11'd100;
        delay  = 19'h00A00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset outputs", int'({out, valid, busy, rd_en, rd_addr}), 0);
        end
        start = 1'b0;
        rstn  = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b0, $sformatf("vec%0d", i));

        // Inputs changed right after acceptance must not leak into the result.
        run_op(vecs[1], 1'b1, "perturb");

        // start held for 12 edges: accepted at edge 0 and edge 6 only.
        mem[90] = 12'sd100;
        mem[89] = 12'sd200;
        pulses = 0; first_at = -1; second_at = -1; pulse_out = 0;
        @(negedge clk);
        wr_ptr = 11'd100;
        delay  = 19'h00A40;
        start  = 1'b1;
        for (int e = 0; e < 18; e++) begin
            @(posedge clk);
            #1;
            if (e == 11) start = 1'b0;
            if (valid) begin
                pulses++;
                if (first_at < 0) first_at = e;
                else if (second_at < 0) second_at = e;
                pulse_out = int'(out);
            end
        end
        $display("op held pulses=%0d first=%0d second=%0d out=%0d", pulses, first_at, second_at, pulse_out);
        check("held pulse count", pulses, 2);
        check("held first pulse", first_at, 4);
        check("held pulse gap", second_at - first_at, 6);
        check("held out", pulse_out, 125);

        // Abort during MUL: no valid pulse, out cleared, next op normal.
        mem[90] = -12'sd2048;
        mem[89] = 12'sd2047;
        @(negedge clk);
        wr_ptr = 11'd100;
        delay  = 19'h00AFF;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk);
            #1;
        end
        check("midop in MUL busy", int'(busy), 1);
        rstn = 1'b0;
        #1;
        check("midop reset out", int'(out), 0);
        check("midop reset busy", int'(busy), 0);
        @(negedge clk);
        rstn = 1'b1;
        saw_valid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (valid) saw_valid++;
        end
        $display("op midop_reset valid_after=%0d out=%0d", saw_valid, out);
        check("midop no valid", saw_valid, 0);
        check("midop out held 0", int'(out), 0);
        run_op(vecs[3], 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
